down_count_checker: RTL

Sequence checker that sits directly downstream of the asynchronous down counter and consumes its count output. It confirms that every observed step is a legal decrement or hold. It counts completed wrap-arounds (0 to all-ones) and flags sequence errors with a pulse, a sticky flag and a saturating error count. It recovers by itself through a resynchronisation state, so a single glitch does not latch the checker off.

---
 rtl/down_count_checker.sv | 134 +++++++++++++
 1 files changed

// File: rtl/down_count_checker.sv
// Checks that a down-counter output only holds or decrements, counts wraps and errors.
// Optional: define DOWNCHK_RELOAD_OK_EN to accept a jump to all-ones from nonzero as a reload.
module down_count_checker #(
    parameter int unsigned WIDTH = 2,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sample_en,
    input  logic [WIDTH-1:0] count_in,
    input  logic             clear,
    output logic             wrap_pulse,
    output logic             seq_err,
    output logic             err_sticky,
    output logic [CNT_W-1:0] wrap_count,
    output logic [CNT_W-1:0] err_count,
    output logic [WIDTH-1:0] last_count,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        ACQUIRE = 2'b00,
        TRACK   = 2'b01,
        RESYNC  = 2'b10
    } state_t;

`ifdef DOWNCHK_RELOAD_OK_EN
    localparam bit RELOAD_OK = 1'b1;
`else
    localparam bit RELOAD_OK = 1'b0;
`endif

    localparam logic [WIDTH-1:0] ONE_W = WIDTH'(1);
    localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

    state_t           state_q, state_d;
    logic [1:0]       good_q, good_d;
    logic [WIDTH-1:0] expected;
    logic             is_hold, is_dec, is_wrap, is_reload, step_ok;
    logic             wrap_ev, err_ev;
    logic [CNT_W-1:0] wrap_count_d, err_count_d;
    logic             err_sticky_d;

    assign expected  = last_count - ONE_W;
    assign is_hold   = (count_in == last_count);
    assign is_wrap   = (last_count == '0) && (count_in == '1);
    assign is_dec    = (last_count != '0) && (count_in == expected);
    assign is_reload = (last_count != '0) && (count_in == '1);
    assign step_ok   = is_dec || is_wrap || (RELOAD_OK && is_reload);

    assign state = state_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ACQUIRE;
            good_q  <= '0;
        end else begin
            state_q <= state_d;
            good_q  <= good_d;
        end
    end

    // Holds in RESYNC neither advance nor clear the good-step run.
    always_comb begin
        state_d = state_q;
        good_d  = good_q;
        if (sample_en) begin
            case (state_q)
                ACQUIRE: begin
                    state_d = TRACK;
                    good_d  = '0;
                end
                TRACK: begin
                    if (!(is_hold || step_ok)) begin
                        state_d = RESYNC;
                        good_d  = '0;
                    end
                end
                RESYNC: begin
                    if (step_ok) begin
                        if (good_q == 2'd1) begin
                            state_d = TRACK;
                            good_d  = '0;
                        end else begin
                            good_d = good_q + 2'd1;
                        end
                    end else if (!is_hold) begin
                        good_d = '0;
                    end
                end
                default: begin
                    state_d = ACQUIRE;
                    good_d  = '0;
                end
            endcase
        end
    end

    always_comb begin
        wrap_ev = sample_en && ((state_q == TRACK) || (state_q == RESYNC)) && is_wrap;
        err_ev  = sample_en && (state_q == TRACK) && !(is_hold || step_ok);

        // Clear zeroes first so a coincident event still lands as a count of one.
        wrap_count_d = clear ? '0 : wrap_count;
        if (wrap_ev && (wrap_count_d != '1))
            wrap_count_d = wrap_count_d + ONE_C;

        err_count_d = clear ? '0 : err_count;
        if (err_ev && (err_count_d != '1))
            err_count_d = err_count_d + ONE_C;

        err_sticky_d = (clear ? 1'b0 : err_sticky) || err_ev;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wrap_pulse <= 1'b0;
            seq_err    <= 1'b0;
            err_sticky <= 1'b0;
            wrap_count <= '0;
            err_count  <= '0;
            last_count <= '0;
        end else begin
            wrap_pulse <= wrap_ev;
            seq_err    <= err_ev;
            err_sticky <= err_sticky_d;
            wrap_count <= wrap_count_d;
            err_count  <= err_count_d;
            if (sample_en)
                last_count <= count_in;
        end
    end

endmodule
